// File: rtl/wishbone_nn_if.sv
// rtl/wishbone_nn_if.sv - Wishbone B4 classic slave bus bundle for the NN staging FIFO

interface wishbone_nn_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   // Slave side: the FIFO block sees requests in and drives ack/read data out
   modport slave (
      input  wbs_stb_i,
      input  wbs_cyc_i,
      input  wbs_we_i,
      input  wbs_sel_i,
      input  wbs_dat_i,
      input  wbs_adr_i,
      output wbs_ack_o,
      output wbs_dat_o
   );

   // Master side: the management core drives requests and observes the reply
   modport master (
      output wbs_stb_i,
      output wbs_cyc_i,
      output wbs_we_i,
      output wbs_sel_i,
      output wbs_dat_i,
      output wbs_adr_i,
      input  wbs_ack_o,
      input  wbs_dat_o
   );
endinterface

// File: rtl/wishbone_nn.sv
// rtl/wishbone_nn.sv - Wishbone slave word FIFO staging data for the NN datapath

module wishbone_nn #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   wishbone_nn_if.slave  wbs
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [5:0] OFS_DATA    = 6'd0;
   localparam logic [5:0] OFS_STATUS  = 6'd1;
   localparam logic [5:0] OFS_CONTROL = 6'd2;

   // Ack sequencer: IDLE accepts a new access, ACK is the single reply cycle
   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [31:0]       r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic              r_underflow;
   logic [31:0]       r_dat_o;

   logic              w_sel;
   logic              w_access;
   logic [5:0]        w_ofs;
   logic              w_empty;
   logic              w_full;
   logic [31:0]       w_status;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_under;
   logic              w_flush;
   logic              w_clear;
   logic              w_rd_ack;
   logic [31:0]       w_rdata;

   // Byte selects and the address bits between the slave decode and the
   // word offset carry no meaning for this block; folded here so they are
   // visibly consumed.
   logic              w_unused;
   assign w_unused = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[23:8], wbs.wbs_adr_i[1:0]};

   assign w_sel   = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                    (wbs.wbs_adr_i[31:24] == BASE_ADR[31:24]);
   // A held strobe is acted on only while no ack is outstanding, so every
   // access produces exactly one push or pop.
   assign w_access = w_sel & (r_state == ST_IDLE);
   assign w_ofs    = wbs.wbs_adr_i[7:2];

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   // Status word assembled from live FIFO state and the sticky flags
   always_comb begin
      w_status       = '0;
      w_status[0]    = w_empty;
      w_status[1]    = w_full;
      w_status[2]    = r_overflow;
      w_status[3]    = r_underflow;
      w_status[15:8] = 8'(r_count);
   end

   // Ack state register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ack next-state: one reply cycle per accepted access, then back to idle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_sel) w_state_nxt = ST_ACK;
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Register decode: turn an accepted access into FIFO/flag actions and read data
   always_comb begin
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_drop   = 1'b0;
      w_under  = 1'b0;
      w_flush  = 1'b0;
      w_clear  = 1'b0;
      w_rd_ack = w_access & ~wbs.wbs_we_i;
      w_rdata  = '0;
      if (w_access) begin
         case (w_ofs)
            OFS_DATA: begin
               if (wbs.wbs_we_i) begin
                  w_push = ~w_full;
                  w_drop = w_full;
               end else begin
                  w_pop   = ~w_empty;
                  w_under = w_empty;
                  w_rdata = w_empty ? 32'h0 : r_mem[r_rd_ptr];
               end
            end
            OFS_STATUS: begin
               if (!wbs.wbs_we_i) w_rdata = w_status;
            end
            OFS_CONTROL: begin
               if (wbs.wbs_we_i) begin
                  w_flush = wbs.wbs_dat_i[0];
                  w_clear = wbs.wbs_dat_i[1];
               end
            end
            default: w_rdata = '0;
         endcase
      end
   end

   // Storage array: written only on an accepted push, no reset needed
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && w_push) begin
         r_mem[r_wr_ptr] <= wbs.wbs_dat_i;
      end
   end

   // Pointers and occupancy; flush wins over the data path
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
         r_count  <= r_count + 1'b1;
      end else if (w_pop) begin
         r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count  <= r_count - 1'b1;
      end
   end

   // Sticky error flags, cleared only by the control register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end
         if (w_drop)  r_overflow  <= 1'b1;
         if (w_under) r_underflow <= 1'b1;
      end
   end

   // Read data register: loads only on a read ack and holds until the next one
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_dat_o <= '0;
      end else if (w_rd_ack) begin
         r_dat_o <= w_rdata;
      end
   end

   assign wbs.wbs_ack_o = (r_state == ST_ACK);
   assign wbs.wbs_dat_o = r_dat_o;

endmodule

// File: tb/tb_wishbone_nn.sv
// tb/tb_wishbone_nn.sv - directed self-checking bench for the wishbone_nn FIFO slave

module tb_wishbone_nn;

   localparam logic [31:0] A_DATA = 32'h3000_0000;
   localparam logic [31:0] A_STAT = 32'h3000_0004;
   localparam logic [31:0] A_CTRL = 32'h3000_0008;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   wishbone_nn_if bus ();

   wishbone_nn #(.DEPTH(8), .BASE_ADR(32'h3000_0000)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (bus)
   );

   always #5 clk = ~clk;

   // Drive one access for a fixed number of edges; report acks seen and data at ack
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input int edges, output int acks, output logic [31:0] rdata);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = 4'hF;
      acks  = 0;
      rdata = 32'h0;
      repeat (edges) begin
         @(posedge clk);
         #1;
         if (bus.wbs_ack_o === 1'b1) begin
            acks++;
            rdata = bus.wbs_dat_o;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
   endtask

   task automatic test_reset();
      int acks;
      logic [31:0] d;
      // an in-flight write held during reset must not push
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_adr_i = A_DATA; bus.wbs_dat_i = 32'h1111_1111; bus.wbs_sel_i = 4'hF;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", bus.wbs_ack_o); end
      n_checks++;
      if (bus.wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", bus.wbs_dat_o); end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      rst = 1'b0;
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (acks !== 1 || d !== 32'h0000_0001) begin
         n_fail++; $display("FAIL reset_status acks %0d data %h want 1 / 00000001", acks, d);
      end
   endtask

   task automatic test_ordered();
      logic [31:0] words [3];
      int acks;
      logic [31:0] d;
      words[0] = 32'h0000_ABBA; words[1] = 32'hDEAD_0000; words[2] = 32'hDEAD_ABBA;
      for (int i = 0; i < 3; i++) begin
         wb_xfer(1'b1, A_DATA, words[i], 2, acks, d);
         n_checks++;
         if (acks !== 1) begin n_fail++; $display("FAIL ordered_wr_ack[%0d] got %0d want 1", i, acks); end
         wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
         n_checks++;
         if (d !== ((i + 1) << 8)) begin
            n_fail++; $display("FAIL ordered_count[%0d] got %h want %h", i, d, (i + 1) << 8);
         end
      end
      for (int i = 0; i < 3; i++) begin
         wb_xfer(1'b0, A_DATA, 32'h0, 2, acks, d);
         n_checks++;
         if (acks !== 1 || d !== words[i]) begin
            n_fail++; $display("FAIL ordered_rd[%0d] acks %0d data %h want 1 / %h", i, acks, d, words[i]);
         end
      end
      // a write must leave the last read data in place
      wb_xfer(1'b1, 32'h3000_000C, 32'h5555_5555, 2, acks, d);
      n_checks++;
      if (bus.wbs_dat_o !== 32'hDEAD_ABBA) begin
         n_fail++; $display("FAIL ordered_hold got %h want deadabba", bus.wbs_dat_o);
      end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL ordered_empty got %h want 00000001", d); end
   endtask

   task automatic test_full_overflow();
      int acks;
      logic [31:0] d;
      for (int i = 1; i <= 9; i++) begin
         wb_xfer(1'b1, A_DATA, 32'(i), 2, acks, d);
         n_checks++;
         if (acks !== 1) begin n_fail++; $display("FAIL full_wr_ack[%0d] got %0d want 1", i, acks); end
      end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0806) begin n_fail++; $display("FAIL full_status got %h want 00000806", d); end
      for (int i = 1; i <= 8; i++) begin
         wb_xfer(1'b0, A_DATA, 32'h0, 2, acks, d);
         n_checks++;
         if (acks !== 1 || d !== 32'(i)) begin
            n_fail++; $display("FAIL full_rd[%0d] acks %0d data %h want 1 / %h", i, acks, d, 32'(i));
         end
      end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0005) begin n_fail++; $display("FAIL full_drained got %h want 00000005", d); end
   endtask

   task automatic test_underflow_wrap();
      int acks;
      logic [31:0] d;
      wb_xfer(1'b0, A_DATA, 32'h0, 2, acks, d);
      n_checks++;
      if (acks !== 1 || d !== 32'h0) begin
         n_fail++; $display("FAIL under_rd acks %0d data %h want 1 / 0", acks, d);
      end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_000D) begin n_fail++; $display("FAIL under_status got %h want 0000000d", d); end
      wb_xfer(1'b1, A_CTRL, 32'h2, 2, acks, d);
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL clear_status got %h want 00000001", d); end
      for (int i = 0; i < 12; i++) begin
         wb_xfer(1'b1, A_DATA, 32'hA500_0000 + 32'(i), 2, acks, d);
         wb_xfer(1'b0, A_DATA, 32'h0, 2, acks, d);
         n_checks++;
         if (acks !== 1 || d !== 32'hA500_0000 + 32'(i)) begin
            n_fail++; $display("FAIL wrap_rd[%0d] acks %0d data %h want 1 / %h", i, acks, d, 32'hA500_0000 + 32'(i));
         end
      end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL wrap_status got %h want 00000001", d); end
   endtask

   task automatic test_flush_decode();
      int acks;
      logic [31:0] d;
      for (int i = 0; i < 3; i++) wb_xfer(1'b1, A_DATA, 32'hF000_0000 + 32'(i), 2, acks, d);
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0300) begin n_fail++; $display("FAIL flush_pre got %h want 00000300", d); end
      wb_xfer(1'b1, A_CTRL, 32'h1, 2, acks, d);
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_post got %h want 00000001", d); end
      wb_xfer(1'b1, A_DATA, 32'h0000_1234, 2, acks, d);
      wb_xfer(1'b0, A_DATA, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL flush_reuse got %h want 00001234", d); end
      wb_xfer(1'b1, 32'h2000_0000, 32'hBAD0_BAD0, 4, acks, d);
      n_checks++;
      if (acks !== 0) begin n_fail++; $display("FAIL decode_wr_ack got %0d want 0", acks); end
      wb_xfer(1'b0, 32'h2000_0000, 32'h0, 4, acks, d);
      n_checks++;
      if (acks !== 0) begin n_fail++; $display("FAIL decode_rd_ack got %0d want 0", acks); end
      wb_xfer(1'b1, A_STAT, 32'hFFFF_FFFF, 2, acks, d);
      n_checks++;
      if (acks !== 1) begin n_fail++; $display("FAIL stat_wr_ack got %0d want 1", acks); end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL decode_status got %h want 00000001", d); end
      wb_xfer(1'b0, 32'h3000_0010, 32'h0, 2, acks, d);
      n_checks++;
      if (acks !== 1 || d !== 32'h0) begin
         n_fail++; $display("FAIL unmapped_rd acks %0d data %h want 1 / 0", acks, d);
      end
      wb_xfer(1'b0, A_CTRL, 32'h0, 2, acks, d);
      n_checks++;
      if (acks !== 1 || d !== 32'h0) begin
         n_fail++; $display("FAIL ctrl_rd acks %0d data %h want 1 / 0", acks, d);
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      logic [31:0] d;
      // strobe held for 4 edges: acks on edges 1 and 3, two pushes
      wb_xfer(1'b1, A_DATA, 32'h0BB0_0BB0, 4, acks, d);
      n_checks++;
      if (acks !== 2) begin n_fail++; $display("FAIL b2b_acks got %0d want 2", acks); end
      wb_xfer(1'b0, A_STAT, 32'h0, 2, acks, d);
      n_checks++;
      if (d !== 32'h0000_0200) begin n_fail++; $display("FAIL b2b_count got %h want 00000200", d); end
   endtask

   initial begin
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
      test_reset();
      test_ordered();
      test_full_overflow();
      test_underflow_wrap();
      test_flush_decode();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wishbone_nn.md
Name: wishbone_nn

Overview:
Wishbone B4 classic slave on the Caravel user-project bus, presenting a 32-bit word FIFO at 0x3000_0000. It stages data words written by the management core for the neural-network datapath and returns them in order on read. Status and control registers sit at the next word addresses. Single clock domain.

Parameters:
DEPTH, 8, number of 32-bit FIFO entries (power of two, ≥2)
BASE_ADR, 32'h3000_0000, slave base address; bits [31:24] decode the slave

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_i  in  1  reset; synchronous, active-high
wbs_stb_i  in  1  strobe
wbs_cyc_i  in  1  bus cycle valid
wbs_we_i  in  1  1 = write, 0 = read
wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  registered acknowledge
wbs_dat_o  out  32  registered read data

Behaviour:
- Reset (wb_rst_i=1 at a rising edge): ack_o=0, dat_o=0, read/write pointers=0, count=0, overflow=0, underflow=0. Reset overrides any in-flight access; no push/pop occurs on that edge.
- Select: sel = cyc & stb & (adr[31:24]==BASE_ADR[31:24]). Unselected addresses: never ack, no state change.
- Handshake: at a rising edge with sel=1 and ack_o=0, the slave performs the access and sets ack_o=1 for exactly one cycle. At the next edge ack_o returns to 0 even if stb/cyc remain high. Each access is acted on exactly once, so a master holding stb for two edges causes one push or one pop. Back-to-back accesses are therefore acked every other cycle.
- Register map (word offset adr[7:2]):
  - 0x00 DATA.
    - Write: push dat_i at the tail.
    - Read: dat_o ← head word on the acking edge, and the head is popped on the same edge.
  - 0x04 STATUS (read-only): [0] empty, [1] full, [2] overflow, [3] underflow, [15:8] count, others 0.
  - 0x08 CONTROL (write): bit0=1 flushes the FIFO (pointers and count to 0); bit1=1 clears the overflow and underflow flags. Reads return 0.
  - All other offsets: reads return 0, writes are ignored; both are acked.
- Read data is valid while ack_o=1 and holds its value until the next read ack.
- Full: a write to DATA is acked, the data is dropped, and overflow is set (sticky).
- Empty: a read of DATA is acked, returns 0, nothing is popped, and underflow is set (sticky).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. empty = (count==0), full = (count==DEPTH).
- Only one bus access per ack, so a push and a pop never occur on the same edge.
- Writes to STATUS are acked and ignored.

Test Plan:
- Reset: hold wb_rst_i=1 for one edge, then release -> ack_o=0, dat_o=0; STATUS read returns 0x0000_0001 (empty).
- Ordered transfer: write 0x0000ABBA, 0xDEAD0000, 0xDEADABBA to 0x3000_0000, holding stb/cyc for 2 edges per write -> each write gets exactly one 1-cycle ack. Three DATA reads then return 0x0000ABBA, 0xDEAD0000, 0xDEADABBA in order, each valid during ack.
- Single-action check: after each write above, STATUS count increments by exactly 1, reaching 3 after the three writes; it reaches 0 after the three reads, and empty=1.
- Full/overflow: write DEPTH+1 words 1..9 -> STATUS shows full=1, overflow=1, count=8. Reads return 1..8; word 9 is lost.
- Empty/underflow and wrap: read DATA when empty -> data 0, acked, underflow=1. Write CONTROL=0x2 -> flags clear. Then 12 interleaved write/read pairs -> each read returns the word just written, across pointer wrap-around.
- Flush and decode: write 3 words, write CONTROL=0x1 -> count=0, empty=1. An access to 0x2000_0000 never acks. Reading 0x3000_0010 acks with 0.
